// File: rtl/fuzzy_risk_engine.sv
// Multi-cycle fuzzy risk engine: fuzzify, 9-rule min/max inference, weighted-singleton defuzzification.
// Optional hysteretic alarm output enabled by defining FUZZY_RISK_ALARM_EN.
module fuzzy_risk_engine #(
  parameter int DATA_W    = 8,
  parameter int FULL      = 100,
  parameter int LO_B      = 30,
  parameter int HI_B      = 70,
  parameter int C_LOW     = 10,
  parameter int C_MED     = 50,
  parameter int C_HIGH    = 90,
  parameter int ALARM_ON  = 70,
  parameter int ALARM_OFF = 50
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] rain_fall,
  input  logic [DATA_W-1:0] soil_moisture,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] risk,
  output logic              out_valid,
  output logic              alarm
);

  localparam int ACC_W = 2*DATA_W + 2;
  localparam int DSH_W = ACC_W + DATA_W;
  localparam int CNT_W = ($clog2(DATA_W) > 4) ? $clog2(DATA_W) : 4;

  localparam logic [DATA_W-1:0] P_FULL  = DATA_W'(FULL);
  localparam logic [DATA_W-1:0] P_LO    = DATA_W'(LO_B);
  localparam logic [DATA_W-1:0] P_HI    = DATA_W'(HI_B);
  localparam logic [DATA_W-1:0] P_SPAN  = DATA_W'(HI_B - LO_B);
  localparam logic [DATA_W+1:0] P_MID2  = (DATA_W+2)'(LO_B + HI_B);
  localparam logic [DATA_W+1:0] P_SPAN2 = (DATA_W+2)'(HI_B - LO_B);
  localparam logic [ACC_W-1:0]  P_CL    = ACC_W'(C_LOW);
  localparam logic [ACC_W-1:0]  P_CM    = ACC_W'(C_MED);
  localparam logic [ACC_W-1:0]  P_CH    = ACC_W'(C_HIGH);
  localparam logic [CNT_W-1:0]  P_LAST  = CNT_W'(DATA_W - 1);

  typedef enum logic [2:0] {S_IDLE, S_FUZZ, S_RULE, S_SUM, S_DIV, S_DONE} state_t;

  function automatic logic [DATA_W-1:0] f_low(input logic [DATA_W-1:0] x);
    if (x <= P_LO)      f_low = P_SPAN;
    else if (x >= P_HI) f_low = '0;
    else                f_low = P_HI - x;
  endfunction

  function automatic logic [DATA_W-1:0] f_high(input logic [DATA_W-1:0] x);
    if (x >= P_HI)      f_high = P_SPAN;
    else if (x <= P_LO) f_high = '0;
    else                f_high = x - P_LO;
  endfunction

  function automatic logic [DATA_W-1:0] f_med(input logic [DATA_W-1:0] x);
    logic [DATA_W+1:0] x2, d;
    x2 = {1'b0, x, 1'b0};
    d  = (x2 >= P_MID2) ? (x2 - P_MID2) : (P_MID2 - x2);
    f_med = (d >= P_SPAN2) ? '0 : DATA_W'(P_SPAN2 - d);
  endfunction

  state_t             r_state;
  logic [DATA_W-1:0]  r_rain, r_soil;
  logic [DATA_W-1:0]  r_mu_r [3];
  logic [DATA_W-1:0]  r_mu_s [3];
  logic [DATA_W-1:0]  r_agg  [3];
  logic [1:0]         r_ri, r_si;
  logic [ACC_W-1:0]   r_rem;
  logic [DSH_W-1:0]   r_dsh;
  logic [DATA_W-1:0]  r_q;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_den_zero;

  logic [DATA_W-1:0]  w_mr, w_ms, w_st;
  logic [2:0]         w_sum;
  logic [1:0]         w_cls;
  logic [ACC_W-1:0]   w_num, w_den;
  logic               w_ge;
  logic [DATA_W-1:0]  w_q_next, w_risk_new;

  always_comb begin
    w_mr = r_mu_r[0];
    w_ms = r_mu_s[0];
    case (r_ri)
      2'd1:    w_mr = r_mu_r[1];
      2'd2:    w_mr = r_mu_r[2];
      default: w_mr = r_mu_r[0];
    endcase
    case (r_si)
      2'd1:    w_ms = r_mu_s[1];
      2'd2:    w_ms = r_mu_s[2];
      default: w_ms = r_mu_s[0];
    endcase
    w_st  = (w_mr < w_ms) ? w_mr : w_ms;
    w_sum = {1'b0, r_ri} + {1'b0, r_si};
    w_cls = (w_sum <= 3'd1) ? 2'd0 : ((w_sum == 3'd2) ? 2'd1 : 2'd2);

    w_num = ACC_W'(r_agg[0]) * P_CL + ACC_W'(r_agg[1]) * P_CM + ACC_W'(r_agg[2]) * P_CH;
    w_den = ACC_W'(r_agg[0]) + ACC_W'(r_agg[1]) + ACC_W'(r_agg[2]);

    // Divisor starts pre-shifted by DATA_W-1; the quotient is bounded by C_HIGH so DATA_W bits suffice.
    w_ge       = (DSH_W'(r_rem) >= r_dsh);
    w_q_next   = {r_q[DATA_W-2:0], w_ge};
    w_risk_new = r_den_zero ? '0 : w_q_next;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      in_ready   <= 1'b1;
      out_valid  <= 1'b0;
      risk       <= '0;
      r_rain     <= '0;
      r_soil     <= '0;
      r_ri       <= '0;
      r_si       <= '0;
      r_rem      <= '0;
      r_dsh      <= '0;
      r_q        <= '0;
      r_cnt      <= '0;
      r_den_zero <= 1'b0;
      for (int unsigned i = 0; i < 3; i++) begin
        r_mu_r[i] <= '0;
        r_mu_s[i] <= '0;
        r_agg[i]  <= '0;
      end
    end else begin
      out_valid <= 1'b0;
      case (r_state)
        S_IDLE: if (in_valid) begin
          r_rain   <= (rain_fall > P_FULL) ? P_FULL : rain_fall;
          r_soil   <= (soil_moisture > P_FULL) ? P_FULL : soil_moisture;
          in_ready <= 1'b0;
          r_state  <= S_FUZZ;
        end
        S_FUZZ: begin
          r_mu_r[0] <= f_low(r_rain);
          r_mu_r[1] <= f_med(r_rain);
          r_mu_r[2] <= f_high(r_rain);
          r_mu_s[0] <= f_low(r_soil);
          r_mu_s[1] <= f_med(r_soil);
          r_mu_s[2] <= f_high(r_soil);
          for (int unsigned i = 0; i < 3; i++) r_agg[i] <= '0;
          r_ri    <= '0;
          r_si    <= '0;
          r_state <= S_RULE;
        end
        S_RULE: begin
          if (w_st > r_agg[w_cls]) r_agg[w_cls] <= w_st;
          if (r_si == 2'd2) begin
            r_si <= '0;
            r_ri <= r_ri + 2'd1;
            if (r_ri == 2'd2) r_state <= S_SUM;
          end else begin
            r_si <= r_si + 2'd1;
          end
        end
        S_SUM: begin
          r_rem      <= w_num;
          r_dsh      <= DSH_W'(w_den) << (DATA_W - 1);
          r_den_zero <= (w_den == '0);
          r_q        <= '0;
          r_cnt      <= '0;
          r_state    <= S_DIV;
        end
        S_DIV: begin
          if (w_ge) r_rem <= r_rem - r_dsh[ACC_W-1:0];
          r_dsh <= r_dsh >> 1;
          r_q   <= w_q_next;
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == P_LAST) begin
            risk      <= w_risk_new;
            out_valid <= 1'b1;
            r_state   <= S_DONE;
          end
        end
        S_DONE: begin
          in_ready <= 1'b1;
          r_state  <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef FUZZY_RISK_ALARM_EN
  localparam logic [DATA_W-1:0] P_AON  = DATA_W'(ALARM_ON);
  localparam logic [DATA_W-1:0] P_AOFF = DATA_W'(ALARM_OFF);
  logic r_alarm;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_alarm <= 1'b0;
    end else if (r_state == S_DIV && r_cnt == P_LAST) begin
      if (w_risk_new >= P_AON)      r_alarm <= 1'b1;
      else if (w_risk_new < P_AOFF) r_alarm <= 1'b0;
    end
  end
  assign alarm = r_alarm;
`else
  assign alarm = 1'b0;
`endif

endmodule

// File: tb/tb_fuzzy_risk_engine.sv
// Self-checking bench for fuzzy_risk_engine: vector table, handshake/reset sequences, random vs. model.
module tb_fuzzy_risk_engine;
  localparam int DATA_W = 8;
  localparam int FULL = 100, LO_B = 30, HI_B = 70;
  localparam int C_LOW = 10, C_MED = 50, C_HIGH = 90;
  localparam int ALARM_ON = 70, ALARM_OFF = 50;
  localparam int LAT = 12 + DATA_W;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [DATA_W-1:0] rain_fall, soil_moisture;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] risk;
  logic              out_valid;
  logic              alarm;

  int checks = 0;
  int errors = 0;
  int ov_count = 0;
  int exp_alarm = 0;

  fuzzy_risk_engine #(
    .DATA_W(DATA_W), .FULL(FULL), .LO_B(LO_B), .HI_B(HI_B),
    .C_LOW(C_LOW), .C_MED(C_MED), .C_HIGH(C_HIGH),
    .ALARM_ON(ALARM_ON), .ALARM_OFF(ALARM_OFF)
  ) dut (
    .clk(clk), .rst_n(rst_n), .rain_fall(rain_fall), .soil_moisture(soil_moisture),
    .in_valid(in_valid), .in_ready(in_ready), .risk(risk), .out_valid(out_valid), .alarm(alarm)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (out_valid) ov_count++;

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // Reference: membership, rule table and weighted average in plain integer arithmetic.
  function automatic int model(input int ra, input int so);
    int x[2];
    int mu[2][3];
    int agg[3];
    int span, d, st, cls, num, den;
    span = HI_B - LO_B;
    x[0] = (ra > FULL) ? FULL : ra;
    x[1] = (so > FULL) ? FULL : so;
    for (int k = 0; k < 2; k++) begin
      mu[k][0] = (x[k] <= LO_B) ? span : (x[k] >= HI_B) ? 0 : HI_B - x[k];
      mu[k][2] = (x[k] >= HI_B) ? span : (x[k] <= LO_B) ? 0 : x[k] - LO_B;
      d = 2*x[k] - LO_B - HI_B;
      if (d < 0) d = -d;
      mu[k][1] = (span - d < 0) ? 0 : span - d;
    end
    for (int c = 0; c < 3; c++) agg[c] = 0;
    for (int r = 0; r < 3; r++)
      for (int s = 0; s < 3; s++) begin
        st  = (mu[0][r] < mu[1][s]) ? mu[0][r] : mu[1][s];
        cls = (r + s <= 1) ? 0 : (r + s == 2) ? 1 : 2;
        if (st > agg[cls]) agg[cls] = st;
      end
    num = agg[0]*C_LOW + agg[1]*C_MED + agg[2]*C_HIGH;
    den = agg[0] + agg[1] + agg[2];
    return (den == 0) ? 0 : num / den;
  endfunction

  function automatic int next_alarm(input int cur, input int r);
`ifdef FUZZY_RISK_ALARM_EN
    if (r >= ALARM_ON) return 1;
    if (r < ALARM_OFF) return 0;
    return cur;
`else
    return 0 * cur + 0 * r;
`endif
  endfunction

  task automatic run_sample(input string name, input int ra, input int so, input int exp);
    int n;
    bit acc;
    @(negedge clk);
    rain_fall = DATA_W'(ra);
    soil_moisture = DATA_W'(so);
    in_valid = 1'b1;
    acc = 0;
    for (int i = 0; i < 50 && !acc; i++) begin
      if (in_ready) acc = 1;
      else @(negedge clk);
    end
    chk({name, " accept"}, int'(acc), 1);
    if (!acc) begin
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    n = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (n == 0) in_valid = 1'b0;
      n++;
      if (out_valid) break;
    end
    chk({name, " latency"}, out_valid ? n : -1, LAT);
    chk({name, " risk"}, int'(risk), exp);
    exp_alarm = next_alarm(exp_alarm, exp);
    chk({name, " alarm"}, int'(alarm), exp_alarm);
    @(negedge clk);
    chk({name, " pulse"}, int'(out_valid), 0);
    chk({name, " ready"}, int'(in_ready), 1);
  endtask

  typedef struct {
    int ra;
    int so;
    int exp;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int n, hi_cnt, ov0, e;
    vecs[0] = '{0, 0, 10};
    vecs[1] = '{100, 100, 90};
    vecs[2] = '{200, 255, 90};
    vecs[3] = '{50, 50, 50};
    vecs[4] = '{40, 50, 44};
    vecs[5] = '{30, 70, 50};
    vecs[6] = '{70, 30, 50};
    vecs[7] = '{0, 100, 50};

    rst_n = 1'b0;
    in_valid = 1'b0;
    rain_fall = '0;
    soil_moisture = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    chk("reset risk", int'(risk), 0);
    chk("reset out_valid", int'(out_valid), 0);
    chk("reset in_ready", int'(in_ready), 1);
    chk("reset alarm", int'(alarm), 0);

    foreach (vecs[i]) begin
      chk("model table", model(vecs[i].ra, vecs[i].so), vecs[i].exp);
      run_sample($sformatf("vec%0d", i), vecs[i].ra, vecs[i].so, vecs[i].exp);
    end

    // Alarm hysteresis sequence 90, 50, 10.
    run_sample("alarm90", 100, 100, 90);
    run_sample("alarm50", 50, 50, 50);
    run_sample("alarm10", 0, 0, 10);

    // in_valid held high across two samples.
    ov0 = ov_count;
    @(negedge clk);
    rain_fall = 8'd100;
    soil_moisture = 8'd100;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rain_fall = 8'd0;
    soil_moisture = 8'd0;
    n = 1;
    hi_cnt = 0;
    while (!out_valid && n < 60) begin
      if (in_ready) hi_cnt++;
      @(negedge clk);
      n++;
    end
    chk("hold latency", out_valid ? n : -1, LAT);
    chk("hold risk A", int'(risk), 90);
    chk("hold ready in DONE", int'(in_ready), 0);
    chk("hold ready busy", hi_cnt, 0);
    @(negedge clk);
    chk("hold ready after", int'(in_ready), 1);
    chk("hold pulse A", int'(out_valid), 0);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    chk("hold B accepted", int'(in_ready), 0);
    n = 1;
    while (!out_valid && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk("hold latency B", out_valid ? n : -1, LAT);
    chk("hold risk B", int'(risk), 10);
    repeat (40) @(negedge clk);
    chk("hold pulse count", ov_count - ov0, 2);
    exp_alarm = next_alarm(next_alarm(exp_alarm, 90), 10);

    // Reset mid-computation.
    run_sample("pre-reset", 100, 100, 90);
    ov0 = ov_count;
    @(negedge clk);
    rain_fall = 8'd50;
    soil_moisture = 8'd50;
    in_valid = 1'b1;
    @(posedge clk);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      in_valid = 1'b0;
    end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    exp_alarm = 0;
    chk("abort risk", int'(risk), 0);
    chk("abort in_ready", int'(in_ready), 1);
    chk("abort alarm", int'(alarm), 0);
    repeat (30) @(negedge clk);
    chk("abort no out_valid", ov_count - ov0, 0);
    run_sample("post-reset", 40, 50, 44);

    // Randomized samples against the model, including clamped inputs.
    for (int i = 0; i < 40; i++) begin
      int ra, so;
      ra = (i % 2 == 0) ? int'($urandom_range(0, FULL)) : int'($urandom_range(0, 255));
      so = (i % 3 == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, FULL));
      e = model(ra, so);
      run_sample($sformatf("rand%0d(%0d,%0d)", i, ra, so), ra, so, e);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got 0 expected 1");
    $fatal(1, "timeout");
  end
endmodule
